// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot/run sequencer.
package boot_ctrl_pkg;

    localparam int INSTR_LEN         = 32;
    localparam int ADDR_LEN          = 32;
    localparam int BOOT_RST_HOLD_DEF = 2;

    typedef enum logic [2:0] {
        BOOT_IDLE    = 3'd0,
        BOOT_LOAD    = 3'd1,
        BOOT_RELEASE = 3'd2,
        BOOT_RUN     = 3'd3,
        BOOT_HALT    = 3'd4
    } boot_state_t;

endpackage

// File: rtl/boot_timer.sv
// Clearable up-counter with a terminal-count compare against a live limit.
module boot_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/boot_ctrl.sv
// Boot and run sequencer: loads imem over valid/ready, releases CPU reset
// for a programmable budget, then parks the CPU in HALT.
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int RST_HOLD   = BOOT_RST_HOLD_DEF,
    parameter int AW         = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW:0]          load_len,
    input  logic [31:0]          run_cycles,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [INSTR_LEN-1:0] in_data,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [AW-1:0]        imem_waddr,
    output logic [INSTR_LEN-1:0] imem_wdata,
    output logic                 cpu_rst,
    input  logic [ADDR_LEN-1:0]  pc_in,
    output logic [ADDR_LEN-1:0]  pc_last,
    output logic [2:0]           state,
    output logic                 done,
    output logic                 err
);

    localparam logic [AW:0] DEPTH_W   = (AW+1)'(IMEM_DEPTH);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);

    boot_state_t cur;
    logic [AW:0] len_q;
    logic [AW:0] wcnt;
    logic [31:0] budget_q;
    logic        hs;
    logic        start_ok;
    logic        tmr_clear;
    logic        tmr_en;
    logic        tmr_tc;
    logic [31:0] tmr_limit;

    assign in_ready = (cur == BOOT_LOAD);
    assign state    = cur;
    assign hs       = in_valid && in_ready;
    assign start_ok = (load_len != '0) && (load_len <= DEPTH_W);

    // One timer serves both phases: it is held at zero outside RELEASE/RUN
    // and re-zeroed on the RELEASE->RUN edge so RUN counts from 0.
    always_comb begin
        tmr_en    = (cur == BOOT_RELEASE) || (cur == BOOT_RUN);
        tmr_clear = !tmr_en || ((cur == BOOT_RELEASE) && tmr_tc);
        tmr_limit = (cur == BOOT_RUN) ? (budget_q - 32'd1) : HOLD_LAST;
    end

    boot_timer #(.W(32)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= BOOT_IDLE;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            pc_last    <= '0;
            len_q      <= '0;
            budget_q   <= '0;
            wcnt       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            err     <= 1'b0;
            imem_we <= hs;
            // The write stage runs independently of the FSM so a word
            // accepted alongside abort still lands in imem.
            if (hs) begin
                imem_waddr <= wcnt[AW-1:0];
                imem_wdata <= in_data;
                wcnt       <= wcnt + (AW+1)'(1);
            end

            if (abort && (cur != BOOT_IDLE)) begin
                if (cur != BOOT_HALT) begin
                    pc_last <= pc_in;
                end
                cur     <= BOOT_HALT;
                cpu_rst <= 1'b1;
                done    <= 1'b1;
            end else begin
                case (cur)
                    BOOT_IDLE, BOOT_HALT: begin
                        if (start) begin
                            if (start_ok) begin
                                len_q    <= load_len;
                                budget_q <= run_cycles;
                                wcnt     <= '0;
                                done     <= 1'b0;
                                cur      <= BOOT_LOAD;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    BOOT_LOAD: begin
                        if (hs && (wcnt == len_q - (AW+1)'(1))) begin
                            if (RST_HOLD == 0) begin
                                cur     <= BOOT_RUN;
                                cpu_rst <= 1'b0;
                            end else begin
                                cur <= BOOT_RELEASE;
                            end
                        end
                    end
                    BOOT_RELEASE: begin
                        if (tmr_tc) begin
                            cur     <= BOOT_RUN;
                            cpu_rst <= 1'b0;
                        end
                    end
                    BOOT_RUN: begin
                        if ((budget_q != '0) && tmr_tc) begin
                            cur     <= BOOT_HALT;
                            cpu_rst <= 1'b1;
                            done    <= 1'b1;
                            pc_last <= pc_in;
                        end
                    end
                    default: cur <= BOOT_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboard bench for boot_ctrl: stimulus queues expected writes and run
// lengths, an independent monitor pops and compares on DUT activity.
module tb_boot_ctrl;
    import boot_ctrl_pkg::*;

    localparam int DEPTH = 256;
    localparam int HOLD  = 2;
    localparam int AW    = 8;

    logic                 clk = 1'b0;
    logic                 rst, start, abort, in_valid;
    logic [AW:0]          load_len;
    logic [31:0]          run_cycles;
    logic [INSTR_LEN-1:0] in_data;
    logic                 in_ready, imem_we;
    logic [AW-1:0]        imem_waddr;
    logic [INSTR_LEN-1:0] imem_wdata;
    logic                 cpu_rst;
    logic [ADDR_LEN-1:0]  pc_in = '0;
    logic [ADDR_LEN-1:0]  pc_last;
    logic [2:0]           state;
    logic                 done, err;

    boot_ctrl #(.IMEM_DEPTH(DEPTH), .RST_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .run_cycles(run_cycles), .abort(abort), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
        .pc_in(pc_in), .pc_last(pc_last), .state(state), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [INSTR_LEN-1:0] data; } wr_t;
    typedef struct { int len; bit halt; } run_t;

    wr_t  exp_wr[$];
    run_t exp_run[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_err  = 0;
    int   seen_err = 0;
    bit   mon_en   = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU stand-in: a fresh random PC every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pc_in = $urandom;
        end
    end

    // Monitor: every imem write, run-length and HALT entry is scored here.
    initial begin
        int cyc = 0;
        int last_we = -1000;
        int low_len = 0;
        bit prev_rst = 1'b1;
        bit prev_done = 1'b0;
        logic [ADDR_LEN-1:0] prev_pc = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (imem_we === 1'b1) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", 64'd1, 64'd0);
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        check("wr_addr", 64'(imem_waddr), 64'(w.addr));
                        check("wr_data", 64'(imem_wdata), 64'(w.data));
                    end
                    last_we = cyc;
                end
                check("in_ready_decode", 64'(in_ready), 64'(state == BOOT_LOAD));
                if (err === 1'b1) seen_err++;
                if (prev_rst && cpu_rst === 1'b0)
                    check("release_gap", 64'(cyc - last_we), 64'(HOLD));
                if (cpu_rst === 1'b0) low_len++;
                if (!prev_rst && cpu_rst === 1'b1) begin
                    if (exp_run.size() == 0) begin
                        check("unexpected_run_end", 64'd1, 64'd0);
                    end else begin
                        run_t r;
                        r = exp_run.pop_front();
                        check("run_len", 64'(low_len), 64'(r.len));
                        check("done_with_cpu_rst", 64'(done), 64'(r.halt));
                    end
                    low_len = 0;
                end
                if (done === 1'b1 && !prev_done) begin
                    check("pc_last", 64'(pc_last), 64'(prev_pc));
                    check("halt_cpu_rst", 64'(cpu_rst), 64'd1);
                    check("halt_state", 64'(state), 64'(BOOT_HALT));
                end
                prev_rst  = (cpu_rst === 1'b1);
                prev_done = (done === 1'b1);
                prev_pc   = pc_in;
            end
        end
    end

    task automatic do_start(int len, logic [31:0] budget);
        start      = 1'b1;
        load_len   = (AW+1)'(len);
        run_cycles = budget;
        tick();
        start = 1'b0;
    endtask

    task automatic load(int len, logic [31:0] budget, bit gappy, int abort_idx);
        int idx = 0;
        int guard = 0;
        bit acc;
        bit aborted = 1'b0;
        logic [INSTR_LEN-1:0] d;
        if (budget != 0 && abort_idx < 0) exp_run.push_back('{int'(budget), 1'b1});
        do_start(len, budget);
        d = $urandom;
        while (idx < len && !aborted && guard < 4*len + 20) begin
            guard++;
            in_valid = gappy ? guard[0] : 1'b1;
            in_data  = d;
            abort    = in_valid && (idx == abort_idx);
            acc      = in_valid && (in_ready === 1'b1);
            @(posedge clk);
            if (acc) begin
                exp_wr.push_back('{AW'(idx), d});
                if (abort) aborted = 1'b1;
                idx++;
                d = $urandom;
            end
            #1;
            abort = 1'b0;
        end
        in_valid = 1'b0;
        if (!aborted && idx < len) check("load_timeout", 64'(idx), 64'(len));
    endtask

    task automatic wait_done(int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic wait_run_low(int limit);
        int k = 0;
        while (cpu_rst !== 1'b0 && k < limit) begin
            tick();
            k++;
        end
        check("run_entered", 64'(cpu_rst), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = '0; load_len = '0; run_cycles = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state",   64'(state),      64'(BOOT_IDLE));
        check("rst_cpu_rst", 64'(cpu_rst),    64'd1);
        check("rst_ready",   64'(in_ready),   64'd0);
        check("rst_we",      64'(imem_we),    64'd0);
        check("rst_waddr",   64'(imem_waddr), 64'd0);
        check("rst_wdata",   64'(imem_wdata), 64'd0);
        check("rst_pc_last", 64'(pc_last),    64'd0);
        check("rst_done",    64'(done),       64'd0);
        check("rst_err",     64'(err),        64'd0);
        mon_en = 1'b1;

        load(24, 100, 1'b0, -1);
        wait_done(400);

        load(4, $urandom_range(1, 20), 1'b1, -1);
        wait_done(200);

        load(DEPTH, 1, 1'b0, -1);
        wait_done(50);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_from_halt", 64'(state), 64'(BOOT_IDLE));
        do_start(0, 5);
        exp_err++;
        tick();
        do_start(DEPTH + 1, 5);
        exp_err++;
        tick();
        check("bad_start_idle", 64'(state), 64'(BOOT_IDLE));

        load(5, 0, 1'b0, -1);
        wait_run_low(50);
        repeat (499) tick();
        abort = 1'b1;
        exp_run.push_back('{500, 1'b1});
        tick();
        abort = 1'b0;
        check("abort_run_state", 64'(state), 64'(BOOT_HALT));
        check("abort_run_cpu_rst", 64'(cpu_rst), 64'd1);

        load(6, 50, 1'b0, 2);
        check("abort_load_state", 64'(state), 64'(BOOT_HALT));
        tick();
        load(3, 7, 1'b0, -1);
        wait_done(100);

        do_start(300, 5);
        exp_err++;
        tick();
        check("bad_start_halt", 64'(state), 64'(BOOT_HALT));

        load(2, 0, 1'b0, -1);
        wait_run_low(50);
        repeat (9) tick();
        rst = 1'b1;
        exp_run.push_back('{10, 1'b0});
        tick();
        rst = 1'b0;
        check("mid_rst_state",   64'(state),   64'(BOOT_IDLE));
        check("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("mid_rst_done",    64'(done),    64'd0);
        check("mid_rst_we",      64'(imem_we), 64'd0);

        repeat (6) begin
            load($urandom_range(1, 16), $urandom_range(1, 30), 1'($urandom_range(0, 1)), -1);
            wait_done(200);
        end

        repeat (3) tick();
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        check("runs_drained",   64'(exp_run.size()), 64'd0);
        check("err_pulses",     64'(seen_err), 64'(exp_err));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
